// File: rtl/fft_buf_pkg.sv
// Shared types and sizing helpers for the overlapped-frame buffer.
// Used by fft_frame_overlap_buffer and fft_buf_ram.
package fft_buf_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STREAM = 2'd2
  } fft_state_e;

  // Address width for a power-of-two RAM depth.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Index width for a power-of-two frame length.
  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/fft_frame_overlap_buffer_if.sv
// Sample-in / frame-out streams of the overlapped-frame buffer.
// Handshake: a beat transfers on the rising clk edge where valid & ready are both 1;
// valid never depends on ready, and data/markers stay stable while valid & !ready.
interface fft_frame_overlap_buffer_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_first;
  logic         out_last;

  // Environment side: decimator upstream, Hanning window downstream.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_first, out_last
  );

  // Buffer side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_first, out_last
  );
endinterface

// File: rtl/fft_buf_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port (1-cycle latency).
// The read register holds its value whenever re_i is low.
module fft_buf_ram
  import fft_buf_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 2048,
  parameter int AW    = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (reset)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_frame_overlap_buffer.sv
// Circular sample store replayed as length-N frames advancing by HOP samples.
// Define FFT_BUF_DROP_ON_FULL_EN to drop samples when full instead of back-pressuring.
module fft_frame_overlap_buffer
  import fft_buf_pkg::*;
#(
  parameter int W     = 16,
  parameter int N     = 1024,
  parameter int HOP   = 512,
  parameter int DEPTH = 2 * N
) (
  input  logic                        clk,
  input  logic                        reset,
  fft_frame_overlap_buffer_if.slave   bus,
  output logic                        frame_start_o,
  output logic [15:0]                 frame_count_o,
`ifdef FFT_BUF_DROP_ON_FULL_EN
  output logic                        overrun_o,
  output logic [15:0]                 drop_count_o,
`endif
  output fft_state_e                  state_dbg_o
);

  localparam int AW = ptr_w(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = idx_w(N);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] N_C      = CW'(N);
  localparam logic [CW-1:0] HOP_C    = CW'(HOP);
  localparam logic [AW-1:0] HOP_A    = AW'(HOP);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  fft_state_e    state_q, state_d;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_base_q, rd_base_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;
  logic [15:0]   frame_count_q, frame_count_d;

  logic          can_store;
  logic          wr_fire;
  logic          out_valid;
  logic          out_fire;
  logic          out_last;
  logic          frame_done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;

  assign can_store = (count_q < DEPTH_C);
  assign wr_fire   = bus.in_valid & can_store;

`ifdef FFT_BUF_DROP_ON_FULL_EN
  logic        drop;
  logic        overrun_q;
  logic [15:0] drop_count_q;

  assign bus.in_ready = 1'b1;
  assign drop         = bus.in_valid & ~can_store;

  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_q    <= 1'b0;
      drop_count_q <= '0;
    end else if (drop) begin
      overrun_q    <= 1'b1;
      if (drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
    end
  end

  assign overrun_o    = overrun_q;
  assign drop_count_o = drop_count_q;
`else
  assign bus.in_ready = can_store;
`endif

  assign out_valid  = (state_q == STREAM);
  assign out_fire   = out_valid & bus.out_ready;
  assign out_last   = out_valid & (rd_idx_q == LAST_IDX);
  assign frame_done = out_fire & out_last;

  // Writes land at rd_base + count, so the active window is never overwritten.
  assign count_d = count_q + CW'(wr_fire) - (frame_done ? HOP_C : '0);

  always_comb begin
    state_d       = state_q;
    rd_base_d     = rd_base_q;
    rd_idx_d      = rd_idx_q;
    frame_count_d = frame_count_q;
    frame_start_o = 1'b0;
    rd_en         = 1'b0;
    // Read-ahead: on a fire fetch the next sample so the stream runs at one per cycle.
    rd_addr       = rd_base_q + AW'(rd_idx_q) + AW'(out_fire);
    unique case (state_q)
      IDLE: begin
        if (count_q >= N_C) state_d = FETCH;
      end
      FETCH: begin
        rd_en         = 1'b1;
        rd_addr       = rd_base_q;
        rd_idx_d      = '0;
        frame_start_o = 1'b1;
        state_d       = STREAM;
      end
      STREAM: begin
        rd_en = out_fire;
        if (out_fire) rd_idx_d = rd_idx_q + IW'(1);
        if (frame_done) begin
          rd_base_d     = rd_base_q + HOP_A;
          frame_count_d = frame_count_q + 16'd1;
          state_d       = (count_d >= N_C) ? FETCH : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_base_q     <= '0;
      count_q       <= '0;
      rd_idx_q      <= '0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_q + AW'(wr_fire);
      rd_base_q     <= rd_base_d;
      count_q       <= count_d;
      rd_idx_q      <= rd_idx_d;
      frame_count_q <= frame_count_d;
    end
  end

  fft_buf_ram #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we_i    (wr_fire),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.in_data),
    .re_i    (rd_en),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign bus.out_valid = out_valid;
  assign bus.out_data  = rd_data;
  assign bus.out_first = out_valid & (rd_idx_q == '0);
  assign bus.out_last  = out_last;
  assign frame_count_o = frame_count_q;
  assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_fft_frame_overlap_buffer.sv
// Directed bench for fft_frame_overlap_buffer with N=8, HOP=4, DEPTH=16.
// Build with FFT_BUF_DROP_ON_FULL_EN defined to include the drop-on-full scenario.
module tb_fft_frame_overlap_buffer;
  import fft_buf_pkg::*;

  localparam int W     = 16;
  localparam int N     = 8;
  localparam int HOP   = 4;
  localparam int DEPTH = 16;

  logic        clk;
  logic        reset;
  logic        frame_start;
  logic [15:0] frame_count;
  fft_state_e  state_dbg;
`ifdef FFT_BUF_DROP_ON_FULL_EN
  logic        overrun;
  logic [15:0] drop_count;
`endif

  fft_frame_overlap_buffer_if #(.W(W)) bus ();

  fft_frame_overlap_buffer #(
    .W(W), .N(N), .HOP(HOP), .DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .frame_start_o (frame_start),
    .frame_count_o (frame_count),
`ifdef FFT_BUF_DROP_ON_FULL_EN
    .overrun_o     (overrun),
    .drop_count_o  (drop_count),
`endif
    .state_dbg_o   (state_dbg)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [W-1:0] d);
    logic acc;
    int   b;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    acc = 1'b0;
    b   = 0;
    while (!acc && b < 64) begin
      @(negedge clk);
      acc = bus.in_ready;
      tick();
      b++;
    end
    check("write_accept", {31'd0, acc}, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic push_frame(input int base);
    for (int i = 0; i < N; i++) exp_q.push_back(W'(base + i));
  endtask

  task automatic wait_drain(input int budget);
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < budget) begin
      @(posedge clk);
      b++;
    end
    check("drain_timeout", exp_q.size(), 0);
    #1;
  endtask

  task automatic apply_reset();
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  // Ramp 0..n-1 on the input while draining frames; random or constant out_ready.
  task automatic run_stream(input int n, input bit rnd, input int budget);
    int   idx;
    int   cyc;
    logic acc;
    idx = 0;
    cyc = 0;
    bus.in_valid = (n > 0);
    bus.in_data  = '0;
    while ((idx < n || exp_q.size() != 0) && cyc < budget) begin
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      acc = bus.in_valid & bus.in_ready;
      tick();
      cyc++;
      if (acc) begin
        idx++;
        bus.in_valid = (idx < n);
        bus.in_data  = W'(idx);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("stream_done", {31'd0, (cyc < budget)}, 32'd1);
  endtask

  // Scoreboard / monitor, sampling on the falling edge.
  int           mon_idx = 0;
  bit           held_v  = 1'b0;
  logic [W-1:0] held_d;
  logic         held_f, held_l;

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (reset) begin
      mon_idx = 0;
      held_v  = 1'b0;
    end else begin
      if (held_v && bus.out_valid) begin
        check("hold_data", 32'(bus.out_data), 32'(held_d));
        check("hold_first", {31'd0, bus.out_first}, {31'd0, held_f});
        check("hold_last", {31'd0, bus.out_last}, {31'd0, held_l});
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 32'(bus.out_data), 32'(e));
          check("out_first", {31'd0, bus.out_first}, {31'd0, (mon_idx == 0)});
          check("out_last", {31'd0, bus.out_last}, {31'd0, (mon_idx == N - 1)});
          mon_idx = (mon_idx + 1) % N;
        end
      end
      held_v = bus.out_valid & ~bus.out_ready;
      held_d = bus.out_data;
      held_f = bus.out_first;
      held_l = bus.out_last;
    end
  end

  initial begin
    int b;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_first", {31'd0, bus.out_first}, 32'd0);
    check("rst_out_last", {31'd0, bus.out_last}, 32'd0);
    check("rst_frame_start", {31'd0, frame_start}, 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    tick();

    // 1: ramp 0..7, frame_start two cycles after the 8th write
    bus.out_ready = 1'b1;
    push_frame(0);
    for (int i = 0; i < N; i++) write(W'(i));
    @(negedge clk);
    check("t1_fs_early", {31'd0, frame_start}, 32'd0);
    check("t1_valid_early", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    check("t1_frame_start", {31'd0, frame_start}, 32'd1);
    @(negedge clk);
    check("t1_first_valid", {31'd0, bus.out_valid}, 32'd1);
    check("t1_first_data", 32'(bus.out_data), 32'd0);
    check("t1_first_flag", {31'd0, bus.out_first}, 32'd1);
    wait_drain(40);
    check("t1_frame_count", 32'(frame_count), 32'd1);
    tick();
    check("t1_idle", 32'(state_dbg), 32'(IDLE));

    // 2: continuous ramp 0..19, overlapping frames with RAM wrap
    apply_reset();
    push_frame(0);
    push_frame(4);
    push_frame(8);
    push_frame(12);
    run_stream(20, 1'b0, 200);
    check("t2_frame_count", 32'(frame_count), 32'd4);

    // 3: fill to DEPTH with output stalled, then release for one frame
    apply_reset();
    for (int i = 0; i < DEPTH; i++) write(W'(i));
    @(negedge clk);
    check("t3_full_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("t3_stalled_valid", {31'd0, bus.out_valid}, 32'd1);
    check("t3_stalled_data", 32'(bus.out_data), 32'd0);
    tick();
    push_frame(0);
    bus.out_ready = 1'b1;
    wait_drain(40);
    bus.out_ready = 1'b0;
    check("t3_in_ready_back", {31'd0, bus.in_ready}, 32'd1);
    check("t3_frame_count", 32'(frame_count), 32'd1);

    // 4: random out_ready with steady input
    apply_reset();
    push_frame(0);
    push_frame(4);
    push_frame(8);
    push_frame(12);
    run_stream(20, 1'b1, 2000);
    check("t4_frame_count", 32'(frame_count), 32'd4);

    // 5: reset in the middle of the first frame at rd_idx=3
    apply_reset();
    push_frame(0);
    for (int i = 0; i < N; i++) write(W'(i));
    b = 0;
    do begin
      @(negedge clk);
      b++;
    end while (!bus.out_valid && b < 20);
    check("t5_valid_seen", {31'd0, bus.out_valid}, 32'd1);
    tick();
    bus.out_ready = 1'b1;
    repeat (3) tick();
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("t5_mid_data", 32'(bus.out_data), 32'd3);
    check("t5_mid_first", {31'd0, bus.out_first}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    check("t5_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("t5_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("t5_rst_last", {31'd0, bus.out_last}, 32'd0);
    check("t5_rst_first", {31'd0, bus.out_first}, 32'd0);
    check("t5_rst_frame_count", 32'(frame_count), 32'd0);
    check("t5_rst_out_data", 32'(bus.out_data), 32'd0);
    check("t5_rst_state", 32'(state_dbg), 32'(IDLE));
    tick();
    reset = 1'b0;
    exp_q.delete();
    bus.out_ready = 1'b1;
    push_frame(100);
    for (int i = 0; i < N; i++) write(W'(100 + i));
    wait_drain(40);
    check("t5_frame_count", 32'(frame_count), 32'd1);
    bus.out_ready = 1'b0;

`ifdef FFT_BUF_DROP_ON_FULL_EN
    // 6: 18 writes into a 16-entry store with output stalled
    apply_reset();
    for (int i = 0; i < DEPTH + 2; i++) write(W'(i));
    @(negedge clk);
    check("t6_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("t6_overrun", {31'd0, overrun}, 32'd1);
    check("t6_drop_count", 32'(drop_count), 32'd2);
    tick();
    push_frame(0);
    bus.out_ready = 1'b1;
    wait_drain(40);
    bus.out_ready = 1'b0;
    check("t6_frame_count", 32'(frame_count), 32'd1);
`endif

    repeat (4) tick();
    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
